// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM front-end blocks that sit ahead of the
// mt48lc16m16a2 controller: FSM encodings, address width and mask constants.
package sdram_pkg;

    localparam int         SDRAM_ADDR_WIDTH = 25;
    localparam logic [3:0] WMASK_READ       = 4'b0000;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        GNT_S0 = 1'b0,
        GNT_S1 = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_arb2.sv
// Two-master arbiter in front of the SDRAM controller: latches one winning
// request, holds it stable until mem_ready, and returns data/ready to its owner.
module sdram_arb2
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s0_valid,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [31:0]           s0_din,
    input  logic [3:0]            s0_wmask,
    output logic [31:0]           s0_dout,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [31:0]           s1_din,
    input  logic [3:0]            s1_wmask,
    output logic [31:0]           s1_dout,
    output logic                  s1_ready,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_dout,
    input  logic                  mem_ready
);

    arb_state_t            r_state;
    grant_t                r_grant;
    grant_t                r_last_grant;
    logic                  r_mem_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_din;
    logic [3:0]            r_mem_wmask;
    logic [31:0]           r_s0_dout;
    logic                  r_s0_ready;
    logic [31:0]           r_s1_dout;
    logic                  r_s1_ready;

    arb_state_t            w_state_nxt;
    grant_t                w_grant_nxt;
    grant_t                w_last_grant_nxt;
    grant_t                w_pick;
    logic                  w_mem_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [31:0]           w_mem_din_nxt;
    logic [3:0]            w_mem_wmask_nxt;
    logic [31:0]           w_s0_dout_nxt;
    logic                  w_s0_ready_nxt;
    logic [31:0]           w_s1_dout_nxt;
    logic                  w_s1_ready_nxt;
    logic                  w_elig0;
    logic                  w_elig1;

    // Only meaningful when at least one master is eligible; ties go to the
    // master that did not win last time, or always to s0 in fixed priority.
    function automatic grant_t pick_grant(input logic   i_e0,
                                          input logic   i_e1,
                                          input grant_t i_last,
                                          input logic   i_rr);
        if (i_e0 && i_e1) begin
            if (i_rr)
                return (i_last == GNT_S0) ? GNT_S1 : GNT_S0;
            else
                return GNT_S0;
        end else if (i_e1) begin
            return GNT_S1;
        end else begin
            return GNT_S0;
        end
    endfunction

    // A master whose completion pulse is still visible is not yet eligible,
    // which keeps a held valid from re-triggering the same access.
    assign w_elig0 = s0_valid && !r_s0_ready;
    assign w_elig1 = s1_valid && !r_s1_ready;
    assign w_pick  = pick_grant(w_elig0, w_elig1, r_last_grant, ROUND_ROBIN);

    always_comb begin
        // NOTE: every signal gets its hold/default value first so no path
        // through the case below leaves one unassigned (that would be a latch).
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_mem_valid_nxt  = r_mem_valid;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_din_nxt    = r_mem_din;
        w_mem_wmask_nxt  = r_mem_wmask;
        w_s0_dout_nxt    = r_s0_dout;
        w_s1_dout_nxt    = r_s1_dout;
        w_s0_ready_nxt   = 1'b0;
        w_s1_ready_nxt   = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_state_nxt      = ARB_BUSY;
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_mem_valid_nxt  = 1'b1;
                    if (w_pick == GNT_S0) begin
                        w_mem_addr_nxt  = s0_addr;
                        w_mem_din_nxt   = s0_din;
                        w_mem_wmask_nxt = s0_wmask;
                    end else begin
                        w_mem_addr_nxt  = s1_addr;
                        w_mem_din_nxt   = s1_din;
                        w_mem_wmask_nxt = s1_wmask;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt     = ARB_IDLE;
                    w_mem_valid_nxt = 1'b0;
                    if (r_grant == GNT_S0) begin
                        w_s0_dout_nxt  = mem_dout;
                        w_s0_ready_nxt = 1'b1;
                    end else begin
                        w_s1_dout_nxt  = mem_dout;
                        w_s1_ready_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples pre-edge values; reset is synchronous to match the
    // controller, which shares resetn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ARB_IDLE;
            r_grant      <= GNT_S0;
            r_last_grant <= GNT_S1;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_wmask  <= WMASK_READ;
            r_s0_dout    <= '0;
            r_s0_ready   <= 1'b0;
            r_s1_dout    <= '0;
            r_s1_ready   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_din    <= w_mem_din_nxt;
            r_mem_wmask  <= w_mem_wmask_nxt;
            r_s0_dout    <= w_s0_dout_nxt;
            r_s0_ready   <= w_s0_ready_nxt;
            r_s1_dout    <= w_s1_dout_nxt;
            r_s1_ready   <= w_s1_ready_nxt;
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wmask = r_mem_wmask;
    assign s0_dout   = r_s0_dout;
    assign s0_ready  = r_s0_ready;
    assign s1_dout   = r_s1_dout;
    assign s1_ready  = r_s1_ready;

endmodule
